// File: rtl/crc8_frame_check.sv
// Receive-side bit-serial CRC-8 checker: one byte per 9 clocks, per-frame residue check.
// Optional saturating failed-frame counter on err_count when CRC8_CHK_ERRCNT_EN is defined.
module crc8_frame_check #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [7:0]  in,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [7:0]  crc_out,
    output logic [7:0]  byte_count
`ifdef CRC8_CHK_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state;
    logic [7:0] crc;
    logic [7:0] sh;
    logic [7:0] run_count;
    logic [2:0] bit_cnt;
    logic       last;
    logic       fb;
    logic [7:0] crc_next;

    always_comb begin
        fb       = crc[7] ^ sh[7];
        crc_next = {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc        <= INIT;
            sh         <= '0;
            bit_cnt    <= '0;
            last       <= 1'b0;
            run_count  <= '0;
            in_ready   <= 1'b1;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_out    <= '0;
            byte_count <= '0;
        end else if (clr) begin
            state      <= IDLE;
            crc        <= INIT;
            run_count  <= '0;
            last       <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh       <= in;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        if (run_count != 8'hFF)
                            run_count <= run_count + 8'd1;
                        if (in_last) begin
                            crc_out <= crc;
                            last    <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    crc     <= crc_next;
                    sh      <= {sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    // Frame results are registered on the final bit so they are valid during DONE.
                    if (bit_cnt == 3'd7) begin
                        if (last) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            frame_ok   <= (crc_next == 8'h00);
                            byte_count <= run_count;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    crc        <= INIT;
                    run_count  <= '0;
                    last       <= 1'b0;
                    frame_done <= 1'b0;
                    state      <= IDLE;
                    in_ready   <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CRC8_CHK_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (frame_done && !frame_ok && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_crc8_frame_check.sv
// Scoreboard bench for crc8_frame_check: expected frame results queued at stimulus time.
module tb_crc8_frame_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  in = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        frame_done;
    logic        frame_ok;
    logic [7:0]  crc_out;
    logic [7:0]  byte_count;
`ifdef CRC8_CHK_ERRCNT_EN
    logic [15:0] err_count;
`endif

    crc8_frame_check #(.POLY(8'h07), .INIT(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in         (in),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .crc_out    (crc_out),
        .byte_count (byte_count)
`ifdef CRC8_CHK_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ok;
        logic [7:0] crc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       got_e;
    logic [7:0] tx_data[$];
    logic       tx_last[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       f;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            f = r[7] ^ b[i];
            r = {r[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    // Move the staged frame into the transmit queues and queue its expected result.
    task automatic add_frame();
        exp_t       e;
        logic [7:0] c;
        int         n;
        c = 8'h00;
        n = frm.size();
        e.crc = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) e.crc = c;
            c = crc8_upd(c, frm[i]);
            tx_data.push_back(frm[i]);
            tx_last.push_back(i == n - 1);
        end
        e.ok  = (c == 8'h00);
        e.cnt = (n > 255) ? 8'hFF : 8'(n);
        exp_q.push_back(e);
        frm.delete();
    endtask

    // Holds in_valid high across the whole stream; checks accept spacing.
    task automatic drive_stream();
        int   prev_cyc;
        logic prev_last;
        int   waited;
        prev_cyc  = -1;
        prev_last = 1'b0;
        while (tx_data.size() > 0) begin
            in       = tx_data[0];
            in_last  = tx_last[0];
            in_valid = 1'b1;
            waited   = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                check("accept_timeout", 32'(waited), 32'd0);
                tx_data.delete();
                tx_last.delete();
                break;
            end
            @(posedge clk);
            if (prev_cyc >= 0)
                check("accept_gap", 32'(cyc - prev_cyc), prev_last ? 32'd10 : 32'd9);
            prev_cyc  = cyc;
            prev_last = tx_last[0];
            void'(tx_data.pop_front());
            void'(tx_last.pop_front());
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                got_e = exp_q.pop_front();
                check("frame_ok", 32'(frame_ok), 32'(got_e.ok));
                check("crc_out", 32'(crc_out), 32'(got_e.crc));
                check("byte_count", 32'(byte_count), 32'(got_e.cnt));
                check("in_ready_in_done", 32'(in_ready), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] c;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_crc_out", 32'(crc_out), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
`ifdef CRC8_CHK_ERRCNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // "123456789" + CRC 0xF4
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'hF4);
        add_frame();
        drive_stream();
        wait_drain();

        // Two frames back to back: good, then bad
        frm.push_back(8'h01); frm.push_back(8'h07); add_frame();
        frm.push_back(8'h01); frm.push_back(8'h08); add_frame();
        drive_stream();
        wait_drain();
`ifdef CRC8_CHK_ERRCNT_EN
        check("err_count_1", 32'(err_count), 32'd1);
`endif

        // Single-byte frames
        frm.push_back(8'h00); add_frame();
        frm.push_back(8'h5A); add_frame();
        drive_stream();
        wait_drain();

        // Long frame: byte_count saturates at 255
        c = 8'h00;
        for (int i = 0; i < 299; i++) begin
            frm.push_back(8'($urandom_range(0, 255)));
            c = crc8_upd(c, frm[i]);
        end
        frm.push_back(c);
        add_frame();
        drive_stream();
        wait_drain();

        // clr mid-byte of the 3rd byte aborts the frame
        tx_data.push_back(8'h11); tx_last.push_back(1'b0);
        tx_data.push_back(8'h22); tx_last.push_back(1'b0);
        tx_data.push_back(8'h33); tx_last.push_back(1'b0);
        drive_stream();
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_hold_count", 32'(byte_count), 32'd255);
        check("clr_hold_ok", 32'(frame_ok), 32'd1);
        frm.push_back(8'h01); frm.push_back(8'h07); add_frame();
        drive_stream();
        wait_drain();

        // Reset mid-frame clears held outputs
        tx_data.push_back(8'h55); tx_last.push_back(1'b0);
        drive_stream();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_frame_ok", 32'(frame_ok), 32'd0);
        check("mid_rst_crc_out", 32'(crc_out), 32'd0);
        check("mid_rst_byte_count", 32'(byte_count), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
`ifdef CRC8_CHK_ERRCNT_EN
        check("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Frame after reset
        frm.push_back(8'h01); frm.push_back(8'h07); add_frame();
        drive_stream();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_frame_check.md
# crc8_frame_check

Receive-side CRC-8 checker. Consumes a byte stream framed by `in_last`, where the final byte of each frame is the transmitted CRC-8. Runs the same bit-serial CRC-8 (8 clocks per byte, MSB first) as the transmit-side `crc8_byte` generator, and reports per frame whether the residue is zero. It sits after the byte deserializer on the link receive path and feeds the packet-accept logic.

## Interface
- `POLY`, 8'h07, CRC-8 generator polynomial (implicit x^8).
- `INIT`, 8'h00, CRC register value at frame start and after `clr`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `clr`  in  1  synchronous abort/clear of the current frame.
- `in`  in  8  received byte.
- `in_valid`  in  1  `in` / `in_last` valid.
- `in_last`  in  1  the byte is the CRC byte and ends the frame.
- `in_ready`  out  1  block can accept a byte this cycle.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `frame_ok`  out  1  residue was zero; valid while `frame_done`, held until next `frame_done`.
- `crc_out`  out  8  CRC computed over the payload (all bytes except the last); held like `frame_ok`.
- `byte_count`  out  8  bytes in the frame including the CRC byte, saturating at 255; held like `frame_ok`.

## Operation
- States: IDLE (`in_ready`=1), SHIFT (8 bit-cycles, `in_ready`=0), DONE (one cycle, `frame_done`=1, `in_ready`=0).
- Accept: `in_valid && in_ready` at an edge. Load the shift register with `in`, set bit counter=0, go to SHIFT. Increment the running count (saturating). For an `in_last` byte, latch `crc_out` <= current CRC register (payload CRC) and set the last flag.
- SHIFT, per edge: `fb = crc[7] ^ sh[7]`; `crc = {crc[6:0],1'b0} ^ (fb ? POLY : 0)`; `sh = sh<<1`. After the 8th bit: go to DONE if the last flag is set, else IDLE.
- DONE: `frame_ok` <= (crc == 0); `byte_count` <= running count. Then the CRC register <= INIT, the running count <= 0, and the state goes to IDLE.
- A single-byte frame (`in_last` on the first byte) has an empty payload: `crc_out`=INIT, and `frame_ok`=1 iff the byte's CRC residue is 0.
- `in` is ignored when not accepted. `in_last` is meaningful only on accept.
- `clr` (priority over everything except reset):
  - state <= IDLE, CRC <= INIT, running count <= 0, last flag <= 0, `frame_done` <= 0.
  - Held outputs (`frame_ok`, `crc_out`, `byte_count`) are unchanged.
  - A byte presented with `clr` is not accepted.
- Reset (`rst_n`=0 at an edge): state IDLE, CRC INIT, all outputs 0, except `in_ready`, which becomes 1 in the cycle after reset.
- Reset or `clr` mid-SHIFT discards the partial byte and the frame. No `frame_done` is produced.

## Timing
- Byte accepted at edge E0; bits processed at E1..E8. `in_ready`=0 from after E0 through E8.
- Non-last byte: `in_ready`=1 after E8, so the next accept is possible at E9. Throughput is 1 byte / 9 clocks.
- Last byte: DONE in the cycle after E8, with `frame_done`=1 for exactly one cycle. `frame_ok`, `crc_out` and `byte_count` are valid in that cycle.
- After DONE: `in_ready`=1 after E9, so the next frame's first byte is accepted at E10 at the earliest.

## Configuration
- `CRC8_CHK_ERRCNT_EN` defined:
  - Adds output `err_count` (out, 16), a count of frames that ended with `frame_ok`=0.
  - Increments in the cycle after a failing `frame_done`, and saturates at 16'hFFFF.
  - Cleared only by reset; `clr` does not affect it.
- Not defined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Send "123456789" (0x31..0x39) then 0xF4 with `in_last` -> `frame_done` pulse, `frame_ok`=1, `crc_out`=0xF4, `byte_count`=10.
- Send 0x01 then 0x07 (last) -> `frame_ok`=1, `crc_out`=0x07. Then send 0x01, 0x08 (last) -> `frame_ok`=0, `crc_out`=0x07; with `CRC8_CHK_ERRCNT_EN` defined, `err_count`=1.
- Single-byte frame 0x00 (last) -> `frame_ok`=1, `crc_out`=0x00, `byte_count`=1. Single-byte frame 0x5A (last) -> `frame_ok`=0.
- Hold `in_valid` continuously -> accepts spaced exactly 9 clocks apart within a frame and 10 clocks across a frame boundary. `in_ready` is never 1 during SHIFT or DONE.
- Assert `clr` at bit 4 of the 3rd byte, then send 0x01, 0x07 (last) -> no `frame_done` for the aborted frame; the new frame gives `frame_ok`=1, `byte_count`=2.
- Drive `rst_n`=0 for one edge mid-frame -> all outputs 0 and `in_ready`=1 on the next cycle. Previously held `frame_ok` is cleared.
